// File: rtl/reorder_buffer_pkg.sv
// Shared out-of-order core definitions: ROB sizing, FU select codes shared with
// decode, and the per-entry payload layout held in the reorder buffer.
package reorder_buffer_pkg;

  localparam int ROB_DEPTH = 8;
  localparam int IDX_W     = 3;
  localparam int PREG_W    = 7;
  localparam int AREG_W    = 6;

  localparam logic [2:0] FU_ALU    = 3'd0;
  localparam logic [2:0] FU_MUL    = 3'd1;
  localparam logic [2:0] FU_DIV    = 3'd2;
  localparam logic [2:0] FU_FPU    = 3'd3;
  localparam logic [2:0] FU_BRANCH = 3'd4;
  localparam logic [2:0] FU_CSR    = 3'd5;
  localparam logic [2:0] FU_LOAD   = 3'd6;
  localparam logic [2:0] FU_STORE  = 3'd7;

  typedef struct packed {
    logic [31:0]       pc;
    logic [31:0]       inst;
    logic [AREG_W-1:0] a_rd;
    logic              has_rd;
    logic [PREG_W-1:0] p_rd_new;
    logic [PREG_W-1:0] p_rd_old;
    logic [2:0]        fu_sel;
    logic [31:0]       redirect_pc;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates at tail, marks completions from two
// writeback ports, retires one done entry per cycle at head, flushes on mispredict.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              dispatch_valid,
  input  logic [31:0]       dispatch_pc,
  input  logic [31:0]       dispatch_inst,
  input  logic [AREG_W-1:0] dispatch_A_rd,
  input  logic              dispatch_has_rd,
  input  logic [PREG_W-1:0] dispatch_P_rd_new,
  input  logic [PREG_W-1:0] dispatch_P_rd_old,
  input  logic [2:0]        dispatch_fu_sel,
  output logic              rob_ready,
  output logic [IDX_W-1:0]  rob_idx,
  input  logic              wb0_valid,
  input  logic [IDX_W-1:0]  wb0_idx,
  input  logic              wb0_mispredict,
  input  logic [31:0]       wb0_redirect_pc,
  input  logic              wb1_valid,
  input  logic [IDX_W-1:0]  wb1_idx,
  output logic              commit_valid,
  output logic [31:0]       commit_pc,
  output logic [AREG_W-1:0] commit_A_rd,
  output logic [PREG_W-1:0] commit_P_rd_new,
  output logic [PREG_W-1:0] commit_P_rd_old,
  output logic              commit_has_rd,
  output logic              commit_store,
  output logic              commit_load,
  output logic              mispredict,
  output logic [31:0]       redirect_pc
);

  localparam logic [IDX_W:0] FULL_COUNT = (IDX_W+1)'(ROB_DEPTH);

  rob_entry_t           entries [ROB_DEPTH];
  logic [ROB_DEPTH-1:0] valid_q;
  logic [ROB_DEPTH-1:0] done_q;
  logic [ROB_DEPTH-1:0] mispred_q;
  logic [IDX_W-1:0]     head;
  logic [IDX_W-1:0]     tail;
  logic [IDX_W:0]       count;
  logic                 accept;

  // Ready depends only on the occupancy register, so a full buffer refuses
  // dispatch even in a cycle where the head retires.
  assign rob_ready = (count != FULL_COUNT);
  assign rob_idx   = tail;
  assign accept    = dispatch_valid && rob_ready && !mispredict;

  assign commit_valid    = !rst && valid_q[head] && done_q[head];
  assign commit_pc       = entries[head].pc;
  assign commit_A_rd     = entries[head].a_rd;
  assign commit_P_rd_new = entries[head].p_rd_new;
  assign commit_P_rd_old = entries[head].p_rd_old;
  assign commit_has_rd   = commit_valid && entries[head].has_rd;
  assign commit_store    = commit_valid && (entries[head].fu_sel == FU_STORE);
  assign commit_load     = commit_valid && (entries[head].fu_sel == FU_LOAD);
  assign mispredict      = commit_valid && mispred_q[head];
  assign redirect_pc     = entries[head].redirect_pc;

  // Port 1 is applied before port 0 so port 0 data wins on a shared index.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= '0;
      done_q    <= '0;
      mispred_q <= '0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      for (int i = 0; i < ROB_DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else if (mispredict) begin
      valid_q   <= '0;
      done_q    <= '0;
      mispred_q <= '0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
    end else begin
      if (wb1_valid && valid_q[wb1_idx]) begin
        done_q[wb1_idx] <= 1'b1;
      end
      if (wb0_valid && valid_q[wb0_idx]) begin
        done_q[wb0_idx] <= 1'b1;
        if (wb0_mispredict) begin
          mispred_q[wb0_idx]           <= 1'b1;
          entries[wb0_idx].redirect_pc <= wb0_redirect_pc;
        end
      end
      if (commit_valid) begin
        valid_q[head] <= 1'b0;
        done_q[head]  <= 1'b0;
        head          <= head + 1'b1;
      end
      if (accept) begin
        valid_q[tail]   <= 1'b1;
        done_q[tail]    <= 1'b0;
        mispred_q[tail] <= 1'b0;
        entries[tail]   <= '{pc:          dispatch_pc,
                             inst:        dispatch_inst,
                             a_rd:        dispatch_A_rd,
                             has_rd:      dispatch_has_rd,
                             p_rd_new:    dispatch_P_rd_new,
                             p_rd_old:    dispatch_P_rd_old,
                             fu_sel:      dispatch_fu_sel,
                             redirect_pc: 32'd0};
        tail            <= tail + 1'b1;
      end
      count <= count + (IDX_W+1)'(accept) - (IDX_W+1)'(commit_valid);
    end
  end

endmodule
